spi_master_xfer: RTL and testbench

//  Parametrised full-duplex SPI master; next generation of the fixed-mode SPI transmitter.

---
 rtl/spi_master_xfer.sv | 144 ++++++++++++++
 tb/tb_spi_master_xfer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master: one word per valid/ready handshake, all four CPOL/CPHA
// modes, MSB/LSB-first order, runtime SCLK divider and per-transfer bit length.
module spi_master_xfer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W) + 1,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_vld,
    output logic              tx_rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_vld,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int K_W = LEN_W + 1;
    localparam logic [K_W-1:0]   K_ONE = 1;
    localparam logic [DIV_W-1:0] H_ONE = 1;
    localparam logic [LEN_W-1:0] N_MAX = LEN_W'(DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  hcnt;
    logic [K_W-1:0]    ecnt;
    logic [K_W-1:0]    k_nxt;
    logic [K_W-1:0]    last_k;
    logic              h_end;
    logic              edge_go;
    logic              accept;

    logic              cpha_q;
    logic              lsb_q;
    logic [DIV_W-1:0]  h_q;
    logic [LEN_W-1:0]  n_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_sh;
    logic              sclk_q;
    logic              mosi_q;

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? H_ONE : d;
    endfunction

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0 || len > N_MAX) ? N_MAX : len;
    endfunction

    // j-th transmitted bit of the word, counted in shift order
    function automatic logic tx_bit(input logic [DATA_W-1:0] w, input logic lsb,
                                    input logic [LEN_W-1:0] n, input logic [K_W-1:0] j);
        logic [K_W-1:0]    pos;
        logic [DATA_W-1:0] s;
        pos = lsb ? j : ({1'b0, n} - K_ONE - j);
        s   = w >> pos;
        return s[0];
    endfunction

    function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] r, input logic b,
                                                 input logic lsb, input logic [K_W-1:0] j);
        if (lsb)
            return r | ({{(DATA_W-1){1'b0}}, b} << j);
        return {r[DATA_W-2:0], b};
    endfunction

    assign h_end  = (hcnt == h_q - H_ONE);
    assign last_k = {n_q, 1'b0} - K_ONE;
    assign accept = tx_vld && (state == IDLE);

    always_comb begin
        state_nxt = state;
        edge_go   = 1'b0;
        k_nxt     = ecnt + K_ONE;
        case (state)
            IDLE:  if (tx_vld) state_nxt = SETUP;
            SETUP: if (h_end) begin
                state_nxt = SHIFT;
                edge_go   = 1'b1;
                k_nxt     = '0;
            end
            SHIFT: if (h_end) begin
                if (ecnt == last_k) state_nxt = HOLD;
                else                edge_go   = 1'b1;
            end
            HOLD:  if (h_end) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            hcnt    <= '0;
            ecnt    <= '0;
            rx_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || state == DONE || h_end) hcnt <= '0;
            else                                         hcnt <= hcnt + H_ONE;
            if (edge_go) ecnt <= k_nxt;
            if (state == HOLD && h_end) rx_data <= rx_sh;
        end
    end

    // Transfer configuration is frozen at acceptance; each SCLK edge either samples or drives
    always_ff @(posedge clk) begin
        if (accept) begin
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            h_q    <= eff_div(clk_div);
            n_q    <= eff_len(length);
            tx_q   <= tx_data;
            rx_sh  <= '0;
            sclk_q <= cpol;
            mosi_q <= cpha ? 1'b0 : tx_bit(tx_data, lsb_first, eff_len(length), '0);
        end else if (edge_go) begin
            sclk_q <= ~sclk_q;
            if (k_nxt[0] == cpha_q)
                rx_sh <= rx_ins(rx_sh, miso, lsb_q, k_nxt >> 1);
            else if (k_nxt != last_k)
                mosi_q <= tx_bit(tx_q, lsb_q, n_q, (k_nxt + K_ONE) >> 1);
        end
    end

    assign tx_rdy = (state == IDLE);
    assign busy   = (state != IDLE);
    assign rx_vld = (state == DONE);
    assign cs_n   = (state == IDLE) || (state == DONE);
    assign sclk   = (state == IDLE) ? cpol : sclk_q;
    assign mosi   = (state == IDLE) ? 1'b0 : mosi_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: vector table through a scoreboard, plus back-to-back,
// mid-transfer config change and mid-transfer reset sequences.
module tb_spi_master_xfer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cpol, cpha, lsb_first;
    logic [7:0]  clk_div;
    logic [5:0]  length;
    logic [31:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [31:0] rx_data;
    logic        rx_vld, busy, sclk, mosi, miso, cs_n;
    int          miso_mode;   // 0 loopback, 1 tied high, 2 tied low, 3 inverted loopback

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 :
                  (miso_mode == 2) ? 1'b0 : ~mosi;

    spi_master_xfer dut (
        .clk(clk), .rstn(rstn), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .clk_div(clk_div), .length(length), .tx_data(tx_data), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    typedef struct {
        logic        cpol, cpha, lsb;
        logic [7:0]  div;
        logic [5:0]  len;
        logic [31:0] tx;
        int          mode;
        logic [31:0] exp_rx, exp_mosi;
        int          exp_lat, exp_edges;
    } vec_t;

    typedef struct {
        logic [31:0] rx, mosi_w;
        int          lat, edges;
        logic        cpol, cpha, lsb;
        int          acc_cyc;
    } sb_t;

    vec_t vecs[7];
    sb_t  q[$];
    sb_t  pending, cur;
    int   checks = 0, failures = 0;
    int   cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0;
    int   edge_cnt = 0, bitk = 0;
    logic [31:0] obs;
    logic prev_sclk, in_xfer = 1'b0, b2b_chk = 1'b0, leading;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: rebuilds the mosi word from the slave's sampling edges
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            q.delete();
            in_xfer = 1'b0;
        end else begin
            if (in_xfer && sclk !== prev_sclk) begin
                edge_cnt++;
                leading = (prev_sclk == cur.cpol);
                if (leading != cur.cpha) begin
                    if (cur.lsb) obs = obs | (32'(mosi) << bitk);
                    else         obs = {obs[30:0], mosi};
                    bitk++;
                end
            end
            prev_sclk = sclk;
            if (rx_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_rx_vld", 32'(rx_vld), 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("rx_data", rx_data, cur.rx);
                    chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                    chk("sclk_edges", 32'(edge_cnt), 32'(cur.edges));
                    chk("mosi_word", obs, cur.mosi_w);
                    chk("cs_n_done", 32'(cs_n), 32'd1);
                    done_cnt++;
                    done_cyc = cyc;
                    in_xfer  = 1'b0;
                end
            end
            if (tx_vld && tx_rdy) begin
                cur = pending;
                cur.acc_cyc = cyc;
                q.push_back(cur);
                if (b2b_chk) begin
                    chk("b2b_gap", 32'(cyc - done_cyc), 32'd1);
                    chk("b2b_cs_n", 32'(cs_n), 32'd1);
                end
                in_xfer   = 1'b1;
                edge_cnt  = 0;
                bitk      = 0;
                obs       = '0;
                prev_sclk = sclk;
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int prev, input string name);
        int n = 0;
        while (acc_cnt == prev && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (acc_cnt == prev) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk({name, "_done_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic apply(input vec_t v);
        cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
        clk_div = v.div; length = v.len; tx_data = v.tx; miso_mode = v.mode;
        pending.rx = v.exp_rx; pending.mosi_w = v.exp_mosi;
        pending.lat = v.exp_lat; pending.edges = v.exp_edges;
        pending.cpol = v.cpol; pending.cpha = v.cpha; pending.lsb = v.lsb;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int prev;
        @(posedge clk); #1;
        apply(v);
        prev   = acc_cnt;
        tx_vld = 1'b1;
        wait_acc(prev, name);
        @(posedge clk); #1;
        tx_vld = 1'b0;
        wait_done(name);
    endtask

    initial begin
        vec_t v;
        int   prev, n, d0;
        //        cpol cpha lsb div   len    tx            mode exp_rx        exp_mosi      lat edges
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd2, 6'd8,  32'h0000_00A5, 0, 32'h0000_00A5, 32'h0000_00A5, 37, 16};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd1, 6'd4,  32'h0000_0003, 1, 32'h0000_000F, 32'h0000_0003, 11, 8};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'd0,  32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 67, 64};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'd3, 6'd5,  32'h0000_0016, 3, 32'h0000_0009, 32'h0000_0016, 37, 10};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'd1, 6'd12, 32'hFFFF_F5A3, 2, 32'h0000_0000, 32'h0000_05A3, 27, 24};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd1, 6'd40, 32'h1234_5678, 3, 32'hEDCB_A987, 32'h1234_5678, 67, 64};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'd4, 6'd1,  32'h0000_0001, 0, 32'h0000_0001, 32'h0000_0001, 17, 2};

        rstn = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = 8'd1; length = 6'd8; tx_data = '0; tx_vld = 1'b0; miso_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_rdy", 32'(tx_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_vld", 32'(rx_vld), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_sclk_cpol1", 32'(sclk), 32'd1);
        cpol = 1'b0; #1;
        chk("rst_sclk_cpol0", 32'(sclk), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) chk("mode3_idle_sclk", 32'(sclk), 32'd1);
        end

        // Two requests with tx_vld held high across both
        v = '{1'b0, 1'b0, 1'b0, 8'd1, 6'd4, 32'h9, 0, 32'h9, 32'h9, 11, 8};
        @(posedge clk); #1;
        apply(v);
        prev = acc_cnt;
        tx_vld = 1'b1;
        wait_acc(prev, "b2b_first");
        @(posedge clk); #1;
        v.tx = 32'h6; v.exp_rx = 32'h6; v.exp_mosi = 32'h6;
        apply(v);
        b2b_chk = 1'b1;
        prev = acc_cnt;
        wait_acc(prev, "b2b_second");
        @(posedge clk); #1;
        b2b_chk = 1'b0;
        tx_vld  = 1'b0;
        wait_done("b2b");
        chk("b2b_done_count", 32'(done_cnt), 32'd9);

        // Configuration inputs change right after acceptance
        v = '{1'b0, 1'b0, 1'b0, 8'd1, 6'd8, 32'hC3, 0, 32'hC3, 32'hC3, 19, 16};
        @(posedge clk); #1;
        apply(v);
        prev = acc_cnt;
        tx_vld = 1'b1;
        wait_acc(prev, "cfgchg");
        @(posedge clk); #1;
        tx_vld = 1'b0; cpha = 1'b1; length = 6'd3; lsb_first = 1'b1;
        tx_data = 32'h0; clk_div = 8'd5;
        wait_done("cfgchg");

        // Async reset in the middle of an N=16 transfer
        v = '{1'b1, 1'b0, 1'b0, 8'd2, 6'd16, 32'hBEEF, 0, 32'hBEEF, 32'hBEEF, 69, 32};
        @(posedge clk); #1;
        apply(v);
        prev = acc_cnt;
        tx_vld = 1'b1;
        wait_acc(prev, "abort");
        @(posedge clk); #1;
        tx_vld = 1'b0;
        n = 0;
        while (edge_cnt < 5 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_reached_edge5", 32'(edge_cnt), 32'd5);
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tx_rdy", 32'(tx_rdy), 32'd1);
        chk("abort_rx_data", rx_data, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_rx_vld", 32'(done_cnt), 32'(d0));
        run_vec(vecs[0], "post_reset");
        chk("post_reset_rx_data", rx_data, 32'h0000_00A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
